stream_bias_activation: RTL and testbench
=========================================

// Module: stream_bias_activation
// PURPOSE
// - Downstream stage of stream_multiply_accumulate: takes each finished dot-product result (out_valid/c) as one neuron pre-activation.
// - Adds a per-neuron bias, saturates, optionally applies ReLU, and tags the last neuron of each output vector.
// - Biases sit in a small writable register file, loaded before inference.
// - Output stream uses the same valid-only, no-backpressure convention as the MAC chain.
// PARAMETERS
// - BITS    16  data width; signed two's complement, same format as the MAC c output.
// - OUTPUTS 10  neurons per output vector (>=2); sizes the bias file and the neuron index counter.
// - AW      $clog2(OUTPUTS)  bias address / neuron index width (localparam).
// PORTS
// - clk           in   1     rising-edge clock.
// - rstn          in   1     synchronous active-low reset.
// - in_valid      in   1     pre-activation valid (driven by MAC out_valid).
// - a             in   BITS  pre-activation value (driven by MAC c), signed.
// - bias_wr_en    in   1     bias write strobe.
// - bias_wr_addr  in   AW    bias index to write; writes with addr >= OUTPUTS are ignored.
// - bias_wr_data  in   BITS  signed bias value.
// - out_valid     out  1     result valid.
// - c             out  BITS  activated result, signed.
// - out_index     out  AW    neuron index of c.
// - out_last      out  1     high with out_valid when out_index == OUTPUTS-1.
// - sat_flag      out  1     sticky; set when any bias add saturated.
// BEHAVIOUR
// - Reset (rstn low at posedge): out_valid=0, c=0, out_index=0, out_last=0, sat_flag=0, neuron counter=0, pipeline valids=0, all biases=0.
// - Reset mid-vector discards in-flight data. The next accepted input is neuron 0.
// - Pipeline, fixed latency 2 cycles: an input accepted at edge N produces out_valid at edge N+2. Fully pipelined, one input per cycle, no stalls.
// - Stage 1 (on in_valid):
//   - register a, idx = counter, bias[counter].
//   - counter = (counter == OUTPUTS-1) ? 0 : counter+1.
// - Stage 2:
//   - sum = sext(a) + sext(bias) in BITS+1 bits.
//   - Saturate to [-2^(BITS-1), 2^(BITS-1)-1]. On clamp, set sat_flag.
//   - Apply activation (see CONFIGURATION), then register c, out_index=idx, out_last=(idx==OUTPUTS-1), out_valid=1.
// - Cycles without in_valid: out_valid=0 two cycles later. c/out_index hold their last value. The counter does not advance.
// - Bias write is committed at the clock edge. A same-cycle stage-1 read of that address returns the OLD value; the new value is seen from the next cycle.
// - Writes are legal at any time, including mid-vector. No bypass.
// - sat_flag clears only on reset.
// - Gaps between vectors need no delimiter. Grouping is purely by the counter.
// CONFIGURATION
// - Macro STREAM_BIAS_RELU_EN:
//   - Defined: ReLU after saturation; negative results become 0, non-negative pass through.
//   - Undefined: identity activation; c = saturated sum, negatives preserved.
// - Latency, sat_flag and indexing are identical in both builds.
// TESTING (BITS=16, OUTPUTS=4)
// - Reset, then bias={10,-20,0,5}, inputs {100,100,100,100} back-to-back
//   -> c={110,80,100,105}, out_index 0..3, out_last only on the 4th, each 2 cycles after its input.
// - a=32767, bias[0]=1 -> c=32767, sat_flag=1. a=-32768, bias[1]=-1 -> c=-32768 without RELU_EN, 0 with RELU_EN.
// - Input -50 to neuron with bias 0 -> c=-50 (macro undefined) / c=0 (STREAM_BIAS_RELU_EN); sat_flag stays 0.
// - Write bias[2]=7 in the same cycle neuron 2 enters stage 1 (old 0), input 1 -> c=1; next vector, neuron 2 with input 1 -> c=8.
// - Send 2 inputs, assert rstn=0 for 1 cycle, send 4 more -> no output from the pre-reset inputs after reset; the first post-reset output has out_index=0, and out_last comes on the 4th.
// - Inputs with 3-cycle gaps over 9 samples -> out_index wraps 0,1,2,3,0,1,2,3,0; out_valid high exactly 9 cycles.

Source files
------------

// File: rtl/stream_bias_activation_if.sv
// Stream bundle for stream_bias_activation: pre-activation input, bias write port,
// and the activated output stream with index/last tags and the sticky saturation flag.
interface stream_bias_activation_if #(
  parameter int unsigned BITS    = 16,
  parameter int unsigned OUTPUTS = 10
);
  localparam int unsigned AW = $clog2(OUTPUTS);

  logic                   in_valid;
  logic signed [BITS-1:0] a;
  logic                   bias_wr_en;
  logic [AW-1:0]          bias_wr_addr;
  logic signed [BITS-1:0] bias_wr_data;
  logic                   out_valid;
  logic signed [BITS-1:0] c;
  logic [AW-1:0]          out_index;
  logic                   out_last;
  logic                   sat_flag;

  modport slave (
    input  in_valid, a, bias_wr_en, bias_wr_addr, bias_wr_data,
    output out_valid, c, out_index, out_last, sat_flag
  );

  modport master (
    output in_valid, a, bias_wr_en, bias_wr_addr, bias_wr_data,
    input  out_valid, c, out_index, out_last, sat_flag
  );
endinterface

// File: rtl/stream_bias_activation.sv
// Per-neuron bias add, saturation and activation stage behind the MAC chain (2-stage pipeline).
// Define STREAM_BIAS_RELU_EN to apply ReLU after saturation; otherwise activation is identity.
module stream_bias_activation #(
  parameter int unsigned BITS    = 16,
  parameter int unsigned OUTPUTS = 10
) (
  input  logic                     clk,
  input  logic                     rstn,
  stream_bias_activation_if.slave  bus
);
  localparam int unsigned AW = $clog2(OUTPUTS);
  localparam int unsigned SW = BITS + 1;

  logic signed [BITS-1:0] bias_q [OUTPUTS];
  logic [AW-1:0]          cnt_q;

  logic                   s1_valid_q;
  logic signed [BITS-1:0] s1_a_q;
  logic signed [BITS-1:0] s1_bias_q;
  logic [AW-1:0]          s1_idx_q;

  logic signed [SW-1:0]   sum_c;
  logic                   ovf_c;
  logic signed [BITS-1:0] sat_c;
  logic signed [BITS-1:0] act_c;

  // Bias file; a write lands at the edge, so a same-edge stage-1 read still sees the old value
  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < OUTPUTS; i++) bias_q[i] <= '0;
    end else if (bus.bias_wr_en) begin
      for (int i = 0; i < OUTPUTS; i++) begin
        if (bus.bias_wr_addr == AW'(i)) bias_q[i] <= bus.bias_wr_data;
      end
    end
  end

  // Stage 1: capture operand, neuron index and its bias; advance the neuron counter
  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt_q      <= '0;
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_bias_q  <= '0;
      s1_idx_q   <= '0;
    end else begin
      s1_valid_q <= bus.in_valid;
      if (bus.in_valid) begin
        s1_a_q    <= bus.a;
        s1_bias_q <= bias_q[cnt_q];
        s1_idx_q  <= cnt_q;
        cnt_q     <= (cnt_q == AW'(OUTPUTS - 1)) ? '0 : cnt_q + AW'(1);
      end
    end
  end

  // Stage 2 datapath: widened add, clamp on overflow, then activation
  always_comb begin
    sum_c = SW'(s1_a_q) + SW'(s1_bias_q);
    ovf_c = sum_c[BITS] != sum_c[BITS-1];
    sat_c = sum_c[BITS-1:0];
    if (ovf_c) begin
      sat_c = sum_c[BITS] ? {1'b1, {(BITS-1){1'b0}}} : {1'b0, {(BITS-1){1'b1}}};
    end
    act_c = sat_c;
`ifdef STREAM_BIAS_RELU_EN
    if (sat_c[BITS-1]) act_c = '0;
`endif
  end

  // Stage 2 output registers; c and out_index hold across idle cycles
  always_ff @(posedge clk) begin
    if (!rstn) begin
      bus.out_valid <= 1'b0;
      bus.c         <= '0;
      bus.out_index <= '0;
      bus.out_last  <= 1'b0;
      bus.sat_flag  <= 1'b0;
    end else begin
      bus.out_valid <= s1_valid_q;
      bus.out_last  <= s1_valid_q && (s1_idx_q == AW'(OUTPUTS - 1));
      if (s1_valid_q) begin
        bus.c         <= act_c;
        bus.out_index <= s1_idx_q;
        if (ovf_c) bus.sat_flag <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_stream_bias_activation.sv
// Scoreboard bench for stream_bias_activation (BITS=16, OUTPUTS=4); expected results
// come from a behavioural model of bias file, counter, saturation and activation.
module tb_stream_bias_activation;
  localparam int unsigned BITS    = 16;
  localparam int unsigned OUTPUTS = 4;
  localparam int unsigned AW      = 2;

  typedef struct {
    logic signed [BITS-1:0] c;
    logic [AW-1:0]          idx;
    logic                   last;
    int                     cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  stream_bias_activation_if #(.BITS(BITS), .OUTPUTS(OUTPUTS)) bus ();

  stream_bias_activation #(.BITS(BITS), .OUTPUTS(OUTPUTS)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  exp_t q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_valid  = 0;
  int   cyc      = 0;
  int   m_bias [OUTPUTS];
  int   m_cnt    = 0;
  bit   m_sat    = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: every valid result is popped and compared against the scoreboard
  always @(negedge clk) begin
    if (bus.out_valid === 1'b1) begin
      exp_t e;
      n_valid++;
      n_checks++;
      if (q.size() == 0) begin
        n_errors++;
        $display("FAIL unexpected_output: got c=%0d idx=%0d with empty scoreboard", bus.c, bus.out_index);
      end else begin
        e = q.pop_front();
        n_checks += 3;
        if (bus.c !== e.c) begin
          n_errors++;
          $display("FAIL c: got %0d expected %0d (idx %0d)", bus.c, e.c, e.idx);
        end
        if (bus.out_index !== e.idx || bus.out_last !== e.last) begin
          n_errors++;
          $display("FAIL index_last: got idx=%0d last=%b expected idx=%0d last=%b", bus.out_index, bus.out_last, e.idx, e.last);
        end
        if (cyc !== e.cyc) begin
          n_errors++;
          $display("FAIL latency: output at cycle %0d expected cycle %0d", cyc, e.cyc);
        end
      end
    end
  end

  // One cycle of stimulus; the model reads the old bias before applying a same-cycle write
  task automatic step(input bit v, input int av, input bit we, input int wa, input int wd);
    exp_t e;
    int   s;
    @(negedge clk);
    bus.in_valid     = v;
    bus.a            = 16'(av);
    bus.bias_wr_en   = we;
    bus.bias_wr_addr = 2'(wa);
    bus.bias_wr_data = 16'(wd);
    if (v) begin
      s = av + m_bias[m_cnt];
      if (s > 32767) begin s = 32767; m_sat = 1'b1; end
      if (s < -32768) begin s = -32768; m_sat = 1'b1; end
`ifdef STREAM_BIAS_RELU_EN
      if (s < 0) s = 0;
`endif
      e.c    = 16'(s);
      e.idx  = 2'(m_cnt);
      e.last = (m_cnt == OUTPUTS - 1);
      e.cyc  = cyc + 2;
      q.push_back(e);
      m_cnt = (m_cnt == OUTPUTS - 1) ? 0 : m_cnt + 1;
    end
    if (we && wa < OUTPUTS) m_bias[wa] = wd;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 0, 1'b0, 0, 0);
  endtask

  task automatic apply_reset(input int n);
    @(negedge clk);
    bus.in_valid   = 1'b0;
    bus.bias_wr_en = 1'b0;
    rstn = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    q.delete();
    m_cnt = 0;
    m_sat = 1'b0;
    for (int i = 0; i < OUTPUTS; i++) m_bias[i] = 0;
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic check_drained(input string name);
    n_checks += 2;
    if (q.size() != 0) begin
      n_errors++;
      $display("FAIL %s_drain: %0d results never produced", name, q.size());
    end
    if (bus.sat_flag !== m_sat) begin
      n_errors++;
      $display("FAIL %s_sat_flag: got %b expected %b", name, bus.sat_flag, m_sat);
    end
  endtask

  task automatic test_reset;
    bus.in_valid = 1'b0; bus.a = '0;
    bus.bias_wr_en = 1'b0; bus.bias_wr_addr = '0; bus.bias_wr_data = '0;
    apply_reset(2);
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.c !== 16'sd0 || bus.out_index !== 2'd0 ||
        bus.out_last !== 1'b0 || bus.sat_flag !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_values: got valid=%b c=%0d idx=%0d last=%b sat=%b expected all 0",
               bus.out_valid, bus.c, bus.out_index, bus.out_last, bus.sat_flag);
    end
  endtask

  task automatic test_basic;
    int b [4] = '{10, -20, 0, 5};
    for (int i = 0; i < 4; i++) step(1'b0, 0, 1'b1, i, b[i]);
    for (int i = 0; i < 4; i++) step(1'b1, 100, 1'b0, 0, 0);
    idle(4);
    check_drained("basic");
  endtask

  task automatic test_negative;
    int v [4] = '{0, 0, -50, 0};
    for (int i = 0; i < 4; i++) step(1'b1, v[i], 1'b0, 0, 0);
    idle(4);
    check_drained("negative");
  endtask

  task automatic test_bias_write_collision;
    step(1'b1, 1, 1'b0, 0, 0);
    step(1'b1, 1, 1'b0, 0, 0);
    step(1'b1, 1, 1'b1, 2, 7);
    step(1'b1, 1, 1'b0, 0, 0);
    for (int i = 0; i < 4; i++) step(1'b1, 1, 1'b0, 0, 0);
    idle(4);
    check_drained("collision");
  endtask

  task automatic test_saturation;
    step(1'b0, 0, 1'b1, 0, 1);
    step(1'b0, 0, 1'b1, 1, -1);
    step(1'b1, 32767, 1'b0, 0, 0);
    step(1'b1, -32768, 1'b0, 0, 0);
    step(1'b1, 0, 1'b0, 0, 0);
    step(1'b1, 0, 1'b0, 0, 0);
    idle(4);
    check_drained("saturation");
  endtask

  task automatic test_reset_mid_vector;
    step(1'b1, 3, 1'b0, 0, 0);
    step(1'b1, 4, 1'b0, 0, 0);
    apply_reset(1);
    n_valid = 0;
    for (int i = 0; i < 4; i++) step(1'b1, 200 + i, 1'b0, 0, 0);
    idle(4);
    n_checks++;
    if (n_valid != 4) begin
      n_errors++;
      $display("FAIL reset_mid_count: got %0d valid outputs expected 4", n_valid);
    end
    check_drained("reset_mid");
  endtask

  task automatic test_gaps;
    n_valid = 0;
    for (int i = 0; i < 9; i++) begin
      step(1'b1, i * 7 - 20, 1'b0, 0, 0);
      idle(3);
    end
    idle(2);
    n_checks++;
    if (n_valid != 9) begin
      n_errors++;
      $display("FAIL gaps_count: got %0d valid cycles expected 9", n_valid);
    end
    check_drained("gaps");
  endtask

  initial begin
    test_reset;
    test_basic;
    test_negative;
    test_bias_write_collision;
    test_saturation;
    test_reset_mid_vector;
    test_gaps;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
